// File: rtl/da_tap_feeder_if.sv
// Sample-in / tap-out / result-back bundle between the DA tap feeder and its environment.
// The slave view belongs to the feeder; the master view drives samples and returns engine results.
interface da_tap_feeder_if;
  logic [2:0] x_in;
  logic       x_valid;
  logic       x_ready;
  logic [2:0] x_out0;
  logic [2:0] x_out1;
  logic [2:0] x_out2;
  logic       da_start;
  logic [5:0] y_da;
  logic [5:0] y_out;
  logic       y_valid;

  modport slave (
    input  x_in, x_valid, y_da,
    output x_ready, x_out0, x_out1, x_out2, da_start, y_out, y_valid
  );

  modport master (
    output x_in, x_valid, y_da,
    input  x_ready, x_out0, x_out1, x_out2, da_start, y_out, y_valid
  );
endinterface

// File: rtl/da_tap_feeder.sv
// Feeds a 3-tap sample delay line into the DA engine and captures its result DA_LAT cycles later.
// Accepts one sample per DA_LAT+1 cycles; x_ready is low for the whole wait window.
module da_tap_feeder #(
  parameter int DA_LAT = 5
) (
  input  logic            clk,
  input  logic            reset,
  da_tap_feeder_if.slave  tap
);

  localparam logic [3:0] CNT_LOAD = 4'(DA_LAT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [1:0] fill;
  logic       accept;
  logic       capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tap.x_valid) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign tap.x_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap.x_out0   <= '0;
      tap.x_out1   <= '0;
      tap.x_out2   <= '0;
      tap.da_start <= 1'b0;
      tap.y_out    <= '0;
      tap.y_valid  <= 1'b0;
      cnt          <= '0;
      fill         <= '0;
    end else begin
      tap.da_start <= 1'b0;
      tap.y_valid  <= 1'b0;
      if (accept) begin
        tap.x_out2   <= tap.x_out1;
        tap.x_out1   <= tap.x_out0;
        tap.x_out0   <= tap.x_in;
        tap.da_start <= 1'b1;
        cnt          <= CNT_LOAD;
        if (fill != 2'd3) begin
          fill <= fill + 2'd1;
        end
      end else if (capture) begin
        tap.y_out <= tap.y_da;
        // Until three samples are in the line the engine sums stale zero taps.
        tap.y_valid <= (fill == 2'd3);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_da_tap_feeder.sv
// Directed bench for da_tap_feeder: reset, priming, tap order, stalls, latency corners, negative data.
module tb_da_tap_feeder;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  da_tap_feeder_if if0 ();
  da_tap_feeder_if if1 ();
  da_tap_feeder_if if15 ();

  da_tap_feeder #(.DA_LAT(5))  u_dut0  (.clk(clk), .reset(reset), .tap(if0));
  da_tap_feeder #(.DA_LAT(1))  u_dut1  (.clk(clk), .reset(reset), .tap(if1));
  da_tap_feeder #(.DA_LAT(15)) u_dut15 (.clk(clk), .reset(reset), .tap(if15));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int yv0    = 0;
  int ds0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.y_valid  === 1'b1) yv0++;
    if (if0.da_start === 1'b1) ds0++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample on if0 until accepted, then wait for its capture.
  task automatic send0(input logic [2:0] x, input logic [5:0] y,
                       output int acc, output int vld);
    int n;
    if0.x_in    = x;
    if0.x_valid = 1'b1;
    if0.y_da    = y;
    n = 0;
    do begin
      tick();
      n++;
    end while (if0.da_start !== 1'b1 && n < 40);
    chk("send_accept", int'(if0.da_start), 1);
    acc = cyc;
    n = 0;
    do begin
      tick();
      n++;
    end while (if0.x_ready !== 1'b1 && n < 40);
    chk("send_capture", int'(if0.x_ready), 1);
    vld = int'(if0.y_valid);
    if0.x_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, v;

    if0.x_in = 3'd5;  if0.x_valid = 1'b0;  if0.y_da = '0;
    if1.x_in = '0;    if1.x_valid = 1'b0;  if1.y_da = '0;
    if15.x_in = '0;   if15.x_valid = 1'b0; if15.y_da = '0;

    // Reset held while x_valid toggles
    for (int i = 0; i < 4; i++) begin
      if0.x_valid = i[0];
      tick();
    end
    chk("rst_x_ready", int'(if0.x_ready), 1);
    chk("rst_x_out0", int'(if0.x_out0), 0);
    chk("rst_x_out1", int'(if0.x_out1), 0);
    chk("rst_x_out2", int'(if0.x_out2), 0);
    chk("rst_da_start", int'(if0.da_start), 0);
    chk("rst_y_out", int'(if0.y_out), 0);
    chk("rst_y_valid", int'(if0.y_valid), 0);
    chk("rst_no_start", ds0, 0);

    // Release with x_valid already high: accept on the first edge
    if0.x_valid = 1'b1;
    reset = 1'b0;
    tick();
    chk("rel_da_start", int'(if0.da_start), 1);
    chk("rel_x_out0", int'(if0.x_out0), 5);
    chk("rel_x_ready", int'(if0.x_ready), 0);

    // Reset two cycles into the wait window
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_x_out0", int'(if0.x_out0), 0);
    chk("mid_x_ready", int'(if0.x_ready), 1);
    chk("mid_da_start", int'(if0.da_start), 0);
    if0.x_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("mid_no_y_valid", yv0, 0);
    chk("mid_y_out", int'(if0.y_out), 0);

    // Priming with 1,2,3 back to back
    send0(3'd1, 6'd9, a1, v);
    chk("prime1_y_valid", v, 0);
    chk("prime1_y_out", int'(if0.y_out), 9);
    send0(3'd2, 6'd10, a2, v);
    chk("prime2_y_valid", v, 0);
    chk("prime2_y_out", int'(if0.y_out), 10);
    chk("prime2_spacing", a2 - a1, 6);
    send0(3'd3, 6'd22, a3, v);
    chk("prime3_y_valid", v, 1);
    chk("prime3_y_out", int'(if0.y_out), 22);
    chk("prime3_spacing", a3 - a2, 6);
    chk("prime3_x_out0", int'(if0.x_out0), 3);
    chk("prime3_x_out1", int'(if0.x_out1), 2);
    chk("prime3_x_out2", int'(if0.x_out2), 1);
    tick();
    chk("prime_y_valid_pulses", yv0, 1);

    // x_valid held with a new value during the wait window
    if0.x_in = 3'd7; if0.x_valid = 1'b1; if0.y_da = 6'd33;
    tick();
    chk("stall_da_start", int'(if0.da_start), 1);
    chk("stall_x_out0", int'(if0.x_out0), 7);
    if0.x_in = 3'd6;
    repeat (4) tick();
    chk("stall_hold_x_out0", int'(if0.x_out0), 7);
    chk("stall_hold_x_out1", int'(if0.x_out1), 3);
    chk("stall_hold_x_out2", int'(if0.x_out2), 2);
    chk("stall_x_ready", int'(if0.x_ready), 0);
    chk("stall_start_count", ds0, 5);
    tick();
    chk("stall_cap_ready", int'(if0.x_ready), 1);
    chk("stall_cap_y_out", int'(if0.y_out), 33);
    chk("stall_cap_y_valid", int'(if0.y_valid), 1);
    if0.x_valid = 1'b0;
    if0.x_in = 3'd5;

    // Idle without x_valid
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_x_ready", int'(if0.x_ready), 1);
    end
    chk("idle_x_out0", int'(if0.x_out0), 7);
    chk("idle_start_count", ds0, 5);
    chk("idle_y_valid_count", yv0, 2);

    // Negative samples and result
    for (int k = 0; k < 3; k++) begin
      send0(3'b100, 6'b110000, a1, v);
      chk("neg_y_valid", v, 1);
    end
    chk("neg_x_out0", int'(if0.x_out0), 4);
    chk("neg_x_out1", int'(if0.x_out1), 4);
    chk("neg_x_out2", int'(if0.x_out2), 4);
    chk("neg_y_out", int'(if0.y_out), 48);

    // DA_LAT=1: one accept every two cycles
    if1.x_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if1.x_in = 3'(k + 1);
      if1.y_da = 6'(20 + k);
      tick();
      chk("l1_da_start", int'(if1.da_start), 1);
      chk("l1_x_out0", int'(if1.x_out0), k + 1);
      chk("l1_x_ready_wait", int'(if1.x_ready), 0);
      tick();
      chk("l1_x_ready_cap", int'(if1.x_ready), 1);
      chk("l1_y_out", int'(if1.y_out), 20 + k);
      chk("l1_y_valid", int'(if1.y_valid), (k >= 2) ? 1 : 0);
    end
    if1.x_valid = 1'b0;
    chk("l1_x_out1", int'(if1.x_out1), 3);
    chk("l1_x_out2", int'(if1.x_out2), 2);

    // DA_LAT=15: y_da changes every cycle; only the 15th edge value is kept
    if15.x_in = 3'd3; if15.x_valid = 1'b1; if15.y_da = 6'd63;
    tick();
    chk("l15_da_start", int'(if15.da_start), 1);
    if15.x_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if15.y_da = 6'(k);
      tick();
      if (k < 15) chk("l15_x_ready_wait", int'(if15.x_ready), 0);
      if (k == 14) chk("l15_y_out_hold", int'(if15.y_out), 0);
    end
    chk("l15_y_out", int'(if15.y_out), 15);
    chk("l15_x_ready", int'(if15.x_ready), 1);
    chk("l15_y_valid", int'(if15.y_valid), 0);
    if15.y_da = 6'd40;
    tick();
    chk("l15_y_out_held", int'(if15.y_out), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/da_tap_feeder.md
# da_tap_feeder

Sample-side front end for the bit-serial distributed-arithmetic (DA) sum-of-product engine. It accepts a stream of 3-bit samples with a valid/ready handshake and maintains a 3-tap delay line that drives the engine's three parallel input words. It issues one start pulse per sample, waits a fixed DA latency, and then captures the engine's 6-bit result into a registered output with a one-cycle valid strobe. It is the counterpart of the DA engine: it produces the engine's inputs and consumes its result.

## Interface
- DA_LAT, default 5: number of clock cycles from a sample accept to the result capture (range 1..15; 5 matches one DA frame: 1 load cycle plus 4 shift cycles).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- x_in  in  3  input sample, two's complement.
- x_valid  in  1  x_in holds a valid sample.
- x_ready  out  1  block can accept a sample this cycle.
- x_out0  out  3  newest tap (to DA engine input word 0).
- x_out1  out  3  tap delayed by 1 sample (to DA engine word 1).
- x_out2  out  3  tap delayed by 2 samples (to DA engine word 2).
- da_start  out  1  one-cycle pulse: taps are updated, the DA engine begins.
- y_da  in  6  result from the DA engine, two's complement.
- y_out  out  6  captured result, held until the next capture.
- y_valid  out  1  one-cycle strobe: y_out was updated on the previous edge.

## Operation
- The FSM has two states, IDLE and WAIT. Reset state is IDLE.
- x_ready = 1 only in IDLE (combinational decode of the state register).
- Accept = x_valid && x_ready at a rising edge. On accept:
  - x_out2 <= x_out1; x_out1 <= x_out0; x_out0 <= x_in.
  - da_start <= 1.
  - cnt <= DA_LAT-1.
  - state <= WAIT.
  - fill <= min(fill+1, 3), where fill is a 2-bit saturating counter.
- x_valid while not in IDLE is ignored: no tap change and no state change. The source must hold x_valid/x_in until accepted.
- WAIT, cnt != 0: cnt <= cnt-1.
- WAIT, cnt == 0:
  - y_out <= y_da.
  - state <= IDLE.
  - y_valid <= 1 only if fill == 3; otherwise y_out is still updated but y_valid stays 0. The first two results after reset are priming results and are not flagged.
- da_start and y_valid are registered and default to 0 every cycle unless set as above.
- Taps and y_out hold their values between updates. No arithmetic is performed on data; widths pass through unchanged.

## Timing
- Reset values: state=IDLE, x_ready=1, x_out0/1/2=0, da_start=0, y_out=0, y_valid=0, cnt=0, fill=0.
- Accept at edge E0. Then:
  - da_start is high during cycle E0..E1.
  - WAIT occupies edges E1..E(DA_LAT).
  - y_da is sampled at edge E0+DA_LAT.
  - y_valid is high during cycle E0+DA_LAT..E0+DA_LAT+1, and x_ready is high in the same cycle.
- Earliest next accept is E0+DA_LAT+1. Sustained throughput is 1 sample per DA_LAT+1 cycles (6 cycles at default).
- DA_LAT=1: accept at E0, capture at E1, next accept at E2.
- Asserting reset mid-WAIT aborts immediately and asynchronously. All outputs return to their reset values, the in-flight result is dropped, and fill is cleared so priming restarts.
- A reset release coincident with x_valid=1: the sample is accepted at the first edge after release.

## Test plan
- Reset: hold reset, toggle x_valid with x_in=3'd5 -> all outputs stay at reset values, x_ready=1. Release -> the first accept occurs at the next edge.
- Priming and tap order:
  - Feed 1, 2, 3 back-to-back (x_valid held high).
  - Required: x_out0/1/2 = 3/2/1 after the third accept, and accepts are spaced exactly 6 cycles apart.
  - The bench model drives y_da = 6'd22 at the third capture -> y_out=22 with exactly one y_valid pulse. No y_valid for the first two captures.
- Handshake stall:
  - Hold x_valid=1 with x_in=3'd7 during WAIT -> taps unchanged, no extra da_start.
  - Drop x_valid for 10 cycles in IDLE -> x_ready stays 1 and nothing changes.
- Latency:
  - Set DA_LAT=1 and feed 4 samples -> accepts every 2 cycles.
  - Set DA_LAT=15 -> y_da is sampled exactly 15 edges after the accept (bench changes y_da every cycle to prove the sampling edge).
- Negative data: feed 3'b100 (-4) three times with the bench returning y_da=6'b110000 (-16) -> all taps = 3'b100, y_out=6'b110000.
- Reset mid-WAIT:
  - Assert reset 2 cycles after an accept -> no y_valid, taps=0.
  - After release, the next two results are unflagged again (fill restarted).
